smi_mem_fuzz_write_data_gen: RTL and testbench
==============================================

SMI_MEM_FUZZ_WRITE_DATA_GEN -- requirements
Module: smi_mem_fuzz_write_data_gen

Interface
REQ-001 The block SHALL have no parameters; data word width is fixed at 64 bits (8 bytes).
REQ-002 clk  input  1  system clock; all logic rising-edge triggered.
REQ-003 srst  input  1  reset, synchronous, active-high.
REQ-004 paramsValid  input  1  fuzz test parameter set available.
REQ-005 paramBaseAddr  input  64  burst start byte address; only bits [2:0] are used.
REQ-006 paramByteLength  input  32  burst length in bytes.
REQ-007 paramDataInit  input  64  value of the first data word.
REQ-008 paramDataIncr  input  64  per-word data increment.
REQ-009 paramsStop  output  1  high = parameter set not accepted this cycle.
REQ-010 dataValid  output  1  data word present on output.
REQ-011 dataWord  output  64  generated write data.
REQ-012 dataMask  output  8  byte-valid mask; bit n qualifies bits [8n+7:8n].
REQ-013 dataLast  output  1  marks the final word of a burst.
REQ-014 dataStop  input  1  downstream backpressure.
REQ-015 burstDone  output  1  single-cycle pulse after a burst's last word transfers.

Function
REQ-016 Transfer rule on both interfaces SHALL be valid high and stop low in the same cycle.
REQ-017 The FSM SHALL have states Idle and Stream; paramsStop SHALL be low only in Idle.
REQ-018 In Idle, a parameter transfer SHALL latch all four parameters and move to Stream if the word count is non-zero, else stay in Idle and pulse burstDone next cycle.
REQ-019 Word count SHALL be (addr[2:0] + length + 7) >> 3, computed at 33-bit width with no overflow.
REQ-020 The first data word SHALL be valid in the cycle after parameter acceptance, with dataWord = paramDataInit.
REQ-021 Word i SHALL equal paramDataInit + i*paramDataIncr modulo 2^64, produced by accumulation; no multiplier.
REQ-022 The first-word mask SHALL be 0xFF << addr[2:0], truncated to 8 bits.
REQ-023 For e = (addr[2:0] + length) mod 8, the last-word mask SHALL be 0xFF when e = 0, else (1 << e) - 1.
REQ-024 A single-word burst SHALL use the AND of the first-word and last-word masks.
REQ-025 Middle words SHALL use mask 0xFF.
REQ-026 The output register SHALL hold dataWord, dataMask and dataLast stable while dataValid is high and dataStop is high.
REQ-027 The output register SHALL advance only when dataValid is low or dataStop is low.
REQ-028 Words SHALL stream back-to-back at one per cycle when dataStop is low.
REQ-029 A dataLast transfer SHALL return the FSM to Idle and assert burstDone in the next cycle.
REQ-030 The earliest next parameter acceptance SHALL be the cycle after the return to Idle.
REQ-031 A new burst's first word SHALL never appear in the same cycle as the previous burst's last word.
REQ-032 Parameter inputs SHALL be ignored while in Stream.

Reset
REQ-033 srst SHALL force Idle, dataValid = 0, burstDone = 0 and paramsStop = 0 from the next cycle.
REQ-034 srst mid-burst SHALL discard the burst with no further data words; the parameter latches are non-reset data registers.

Verification
REQ-035 addr 0x1000, len 16, init 5, incr 3, dataStop = 0 -> words 5 then 8, masks 0xFF/0xFF, dataLast on 2nd word, burstDone one cycle later.
REQ-036 addr 0x1003, len 8 -> 2 words, masks 0xF8 then 0x07, dataLast on 2nd word.
REQ-037 addr 0x2002, len 4 -> 1 word, mask 0x3C, dataLast = 1.
REQ-038 init 0xFFFFFFFFFFFFFFFF, incr 2, len 16, addr 0 -> words 0xFFFFFFFFFFFFFFFF then 0x0000000000000001.
REQ-039 dataStop high for 3 cycles on word 2 of a 4-word burst -> word 2 held stable throughout; words 3-4 follow in consecutive cycles once dataStop falls.
REQ-040 srst asserted during word 2 of 4 -> dataValid = 0 next cycle, paramsStop = 0, no burstDone; a new parameter set is then accepted normally.

Source files
------------

// File: rtl/smi_mem_fuzz_write_data_gen.sv
// smi_mem_fuzz_write_data_gen: fuzz-test write data generator.
// Streams one byte-masked 64-bit word per cycle for each accepted burst.
module smi_mem_fuzz_write_data_gen (
  input  logic        clk,
  input  logic        srst,
  input  logic        paramsValid,
  input  logic [63:0] paramBaseAddr,
  input  logic [31:0] paramByteLength,
  input  logic [63:0] paramDataInit,
  input  logic [63:0] paramDataIncr,
  output logic        paramsStop,
  output logic        dataValid,
  output logic [63:0] dataWord,
  output logic [7:0]  dataMask,
  output logic        dataLast,
  input  logic        dataStop,
  output logic        burstDone
);

  typedef enum logic {
    Idle,
    Stream
  } state_t;

  state_t      state;
  logic [2:0]  endLo;
  logic [63:0] incr;
  logic [63:0] nextData;
  logic [29:0] wordsLeft;

  logic [2:0]  inAddrLo;
  logic [32:0] inSum;
  logic [29:0] inCount;
  logic [2:0]  inEnd;
  logic [7:0]  inFirstMask;
  logic        inSingle;
  logic        accept;
  logic        advance;
  logic        unusedAddr;

  function automatic logic [7:0] lastMaskOf(input logic [2:0] e);
    logic [7:0] m;
    m = (8'h01 << e) - 8'h01;
    return (e == 3'd0) ? 8'hFF : m;
  endfunction

  assign unusedAddr  = ^paramBaseAddr[63:3];
  assign inAddrLo    = paramBaseAddr[2:0];
  assign inSum       = {30'd0, inAddrLo}
                     + {1'b0, paramByteLength}
                     + 33'd7;
  assign inCount     = 30'(inSum >> 3);
  assign inEnd       = inAddrLo + paramByteLength[2:0];
  assign inFirstMask = 8'hFF << inAddrLo;
  assign inSingle    = (inCount == 30'd1);

  assign paramsStop = (state != Idle);
  assign accept     = paramsValid && (state == Idle);
  assign advance    = !dataValid || !dataStop;

  // Control path: the only reset state in the block.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= Idle;
      dataValid <= 1'b0;
      burstDone <= 1'b0;
    end else begin
      burstDone <= 1'b0;
      unique case (state)
        Idle: begin
          if (paramsValid) begin
            if (inCount == 30'd0) begin
              burstDone <= 1'b1;
            end else begin
              state     <= Stream;
              dataValid <= 1'b1;
            end
          end
        end
        Stream: begin
          if (advance && dataLast) begin
            state     <= Idle;
            dataValid <= 1'b0;
            burstDone <= 1'b1;
          end
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

  // Datapath: the first word is loaded straight from the inputs, later
  // words come from an accumulator so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      incr      <= paramDataIncr;
      endLo     <= inEnd;
      nextData  <= paramDataInit + paramDataIncr;
      wordsLeft <= inCount - 30'd1;
      dataWord  <= paramDataInit;
      dataMask  <= inSingle ? (inFirstMask & lastMaskOf(inEnd))
                            : inFirstMask;
      dataLast  <= inSingle;
    end else if (state == Stream && advance && !dataLast) begin
      nextData  <= nextData + incr;
      wordsLeft <= wordsLeft - 30'd1;
      dataWord  <= nextData;
      dataMask  <= (wordsLeft == 30'd1) ? lastMaskOf(endLo) : 8'hFF;
      dataLast  <= (wordsLeft == 30'd1);
    end
  end

endmodule

// File: tb/tb_smi_mem_fuzz_write_data_gen.sv
// tb_smi_mem_fuzz_write_data_gen: directed bursts with a queue scoreboard.
// Driver pushes hand-computed words; a negedge monitor pops on transfer.
module tb_smi_mem_fuzz_write_data_gen;

  logic        clk;
  logic        srst;
  logic        paramsValid;
  logic [63:0] paramBaseAddr;
  logic [31:0] paramByteLength;
  logic [63:0] paramDataInit;
  logic [63:0] paramDataIncr;
  logic        paramsStop;
  logic        dataValid;
  logic [63:0] dataWord;
  logic [7:0]  dataMask;
  logic        dataLast;
  logic        dataStop;
  logic        burstDone;

  typedef struct packed {
    logic [63:0] w;
    logic [7:0]  m;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nPass   = 0;
  bit   zeroFlag = 0;

  smi_mem_fuzz_write_data_gen dut (
    .clk            (clk),
    .srst           (srst),
    .paramsValid    (paramsValid),
    .paramBaseAddr  (paramBaseAddr),
    .paramByteLength(paramByteLength),
    .paramDataInit  (paramDataInit),
    .paramDataIncr  (paramDataIncr),
    .paramsStop     (paramsStop),
    .dataValid      (dataValid),
    .dataWord       (dataWord),
    .dataMask       (dataMask),
    .dataLast       (dataLast),
    .dataStop       (dataStop),
    .burstDone      (burstDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [63:0] w, input logic [7:0] m,
                      input logic l);
    exp_t e;
    e.w = w;
    e.m = m;
    e.l = l;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic sendParams(input logic [63:0] a, input logic [31:0] len,
                            input logic [63:0] init, input logic [63:0] inc,
                            input bit words);
    int n = 0;
    while (paramsStop && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("acceptTimeout", 64'(paramsStop), 64'd0);
    paramsValid     = 1'b1;
    paramBaseAddr   = a;
    paramByteLength = len;
    paramDataInit   = init;
    paramDataIncr   = inc;
    @(posedge clk);
    #1;
    paramsValid = 1'b0;
    chk("firstLatency", 64'(dataValid), 64'(words));
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((q.size() != 0 || dataValid || paramsStop) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drainTimeout", 64'(n < 300), 64'd1);
  endtask

  // Monitor state
  bit          pHold = 0;
  bit          pXfer = 0;
  bit          pLast = 0;
  logic [63:0] pWord;
  logic [7:0]  pMask;
  logic        pLastBit;

  always @(negedge clk) begin
    exp_t e;
    bit   xfer;
    if (srst) begin
      pHold = 0;
      pXfer = 0;
      pLast = 0;
    end else begin
      if (pHold) begin
        chk("holdValid", 64'(dataValid), 64'd1);
        chk("holdWord", dataWord, pWord);
        chk("holdMaskLast", {55'd0, dataMask, dataLast},
            {55'd0, pMask, pLastBit});
      end
      if (pXfer && !pLast) chk("backToBack", 64'(dataValid), 64'd1);
      if (pXfer && pLast) begin
        chk("lastGap", 64'(dataValid), 64'd0);
        chk("burstDone", 64'(burstDone), 64'd1);
      end else if (zeroFlag) begin
        chk("zeroDone", 64'(burstDone), 64'd1);
      end else if (burstDone) begin
        chk("spuriousDone", 64'(burstDone), 64'd0);
      end
      if (dataValid) chk("stopInStream", 64'(paramsStop), 64'd1);
      xfer = dataValid && !dataStop;
      if (xfer) begin
        if (q.size() == 0) begin
          chk("unexpectedWord", dataWord, 64'hx);
        end else begin
          e = q.pop_front();
          chk("word", dataWord, e.w);
          chk("mask", 64'(dataMask), 64'(e.m));
          chk("last", 64'(dataLast), 64'(e.l));
        end
      end
      pHold    = dataValid && dataStop;
      pWord    = dataWord;
      pMask    = dataMask;
      pLastBit = dataLast;
      pXfer    = xfer;
      pLast    = xfer && dataLast;
    end
  end

  initial begin
    srst            = 1'b1;
    paramsValid     = 1'b0;
    paramBaseAddr   = '0;
    paramByteLength = '0;
    paramDataInit   = '0;
    paramDataIncr   = '0;
    dataStop        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    chk("rstValid", 64'(dataValid), 64'd0);
    chk("rstStop", 64'(paramsStop), 64'd0);
    chk("rstDone", 64'(burstDone), 64'd0);

    // Aligned two-word burst
    push(64'd5, 8'hFF, 1'b0);
    push(64'd8, 8'hFF, 1'b1);
    sendParams(64'h1000, 32'd16, 64'd5, 64'd3, 1);
    // Unaligned start, two words
    push(64'h100, 8'hF8, 1'b0);
    push(64'h110, 8'h07, 1'b1);
    sendParams(64'h1003, 32'd8, 64'h100, 64'h10, 1);
    // Single word with both masks
    push(64'hABCD, 8'h3C, 1'b1);
    sendParams(64'h2002, 32'd4, 64'hABCD, 64'd1, 1);
    // Data wraps modulo 2^64
    push(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    push(64'h0000_0000_0000_0001, 8'hFF, 1'b1);
    sendParams(64'h0, 32'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1);
    waitDrain();

    // Zero-length burst
    sendParams(64'h0, 32'd0, 64'd9, 64'd9, 0);
    zeroFlag = 1;
    @(posedge clk);
    #1;
    zeroFlag = 0;
    chk("zeroIdle", 64'(paramsStop), 64'd0);

    // Unaligned four-word burst
    push(64'h0, 8'hE0, 1'b0);
    push(64'h0101_0101_0101_0101, 8'hFF, 1'b0);
    push(64'h0202_0202_0202_0202, 8'hFF, 1'b0);
    push(64'h0303_0303_0303_0303, 8'h01, 1'b1);
    sendParams(64'h5, 32'd20, 64'h0, 64'h0101_0101_0101_0101, 1);
    waitDrain();

    // Backpressure on word 2; junk params during Stream are ignored
    push(64'd10, 8'hFF, 1'b0);
    push(64'd20, 8'hFF, 1'b0);
    push(64'd30, 8'hFF, 1'b0);
    push(64'd40, 8'hFF, 1'b1);
    sendParams(64'h0, 32'd32, 64'd10, 64'd10, 1);
    @(posedge clk);
    #1;
    dataStop        = 1'b1;
    paramsValid     = 1'b1;
    paramBaseAddr   = 64'h7;
    paramByteLength = 32'd1;
    paramDataInit   = 64'hDEAD;
    paramDataIncr   = 64'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    dataStop    = 1'b0;
    paramsValid = 1'b0;
    waitDrain();

    // Reset mid-burst
    push(64'd7, 8'hFF, 1'b0);
    sendParams(64'h0, 32'd32, 64'd7, 64'd1, 1);
    @(posedge clk);
    #1;
    srst     = 1'b1;
    dataStop = 1'b1;
    @(posedge clk);
    #1;
    chk("midRstValid", 64'(dataValid), 64'd0);
    chk("midRstStop", 64'(paramsStop), 64'd0);
    chk("midRstDone", 64'(burstDone), 64'd0);
    srst     = 1'b0;
    dataStop = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    chk("postRstValid", 64'(dataValid), 64'd0);
    chk("postRstDone", 64'(burstDone), 64'd0);

    push(64'd5, 8'hFF, 1'b0);
    push(64'd8, 8'hFF, 1'b1);
    sendParams(64'h1000, 32'd16, 64'd5, 64'd3, 1);
    waitDrain();
    repeat (2) @(posedge clk);
    #1;
    chk("leftover", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
